// File: rtl/register_file.sv
// register_file: architectural register file (x0..x31) for the RV32I
// out-of-order core. Each register carries a busy flag and the ROB tag of
// its pending producer. Commits arrive in order from the reorder buffer and
// renames come from the instruction unit. Two combinational source-read
// ports return either the value or the ROB dependency.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward a matching commit
// onto the read ports in the same cycle. Without it, reads show registered
// state only.
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clear,
  input  logic                 regUpdateValid,
  input  logic [4:0]           regUpdateDest,
  input  logic [31:0]          regValue,
  input  logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic                 renameValid,
  input  logic [4:0]           renameDest,
  input  logic [ROB_WIDTH-1:0] renameRobId,
  input  logic [4:0]           rs1,
  output logic                 rs1Busy,
  output logic [31:0]          rs1Value,
  output logic [ROB_WIDTH-1:0] rs1Dep,
  input  logic [4:0]           rs2,
  output logic                 rs2Busy,
  output logic [31:0]          rs2Value,
  output logic [ROB_WIDTH-1:0] rs2Dep
);

  // x0 is hard-wired, so storage covers x1..x31 only.
  logic [31:0]          regs [1:31];
  logic                 busy [1:31];
  logic [ROB_WIDTH-1:0] tag  [1:31];

  logic commit_en;
  logic rename_en;

  assign commit_en = regUpdateValid && (regUpdateDest != 5'd0);
  assign rename_en = renameValid && (renameDest != 5'd0) && !clear;

  // Commit writes, busy release, renames and flush.
  // NOTE: the whole array is reset here on purpose. Readers must see value 0,
  // busy 0 and tag 0 for every register right after reset, so the reset
  // cannot be left off the storage.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
        busy[i] <= 1'b0;
        tag[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every read below use the state
      // from before this edge. The rename assignment comes after the commit
      // release in source order, so on the same register the rename wins.
      if (commit_en) begin
        regs[regUpdateDest] <= regValue;
      end
      if (clear) begin
        // Tags are left alone. They are don't-care while a register is not busy.
        for (int i = 1; i < 32; i++) begin
          busy[i] <= 1'b0;
        end
      end else begin
        // A tag mismatch means a younger rename owns the register, so keep it busy.
        if (commit_en && busy[regUpdateDest] &&
            (tag[regUpdateDest] == regUpdateRobId)) begin
          busy[regUpdateDest] <= 1'b0;
        end
        if (rename_en) begin
          busy[renameDest] <= 1'b1;
          tag[renameDest]  <= renameRobId;
        end
      end
    end
  end

  // Source 1 lookup. It sees pre-rename state, and x0 always reads as zero.
  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    rs1Busy  = 1'b0;
    rs1Value = '0;
    rs1Dep   = '0;
    if (rs1 != 5'd0) begin
      rs1Busy  = busy[rs1];
      rs1Value = regs[rs1];
      rs1Dep   = tag[rs1];
`ifdef REG_FILE_BYPASS_EN
      if (regUpdateValid && (regUpdateDest == rs1) && busy[rs1] &&
          (tag[rs1] == regUpdateRobId)) begin
        rs1Busy  = 1'b0;
        rs1Value = regValue;
      end
`endif
    end
  end

  // Source 2 lookup, same behaviour as source 1.
  always_comb begin
    rs2Busy  = 1'b0;
    rs2Value = '0;
    rs2Dep   = '0;
    if (rs2 != 5'd0) begin
      rs2Busy  = busy[rs2];
      rs2Value = regs[rs2];
      rs2Dep   = tag[rs2];
`ifdef REG_FILE_BYPASS_EN
      if (regUpdateValid && (regUpdateDest == rs2) && busy[rs2] &&
          (tag[rs2] == regUpdateRobId)) begin
        rs2Busy  = 1'b0;
        rs2Value = regValue;
      end
`endif
    end
  end

endmodule
